ring_counter_gen: RTL and testbench

RING_COUNTER_GEN -- requirements
Module: ring_counter_gen

---
 rtl/ring_counter_gen_if.sv | 23 ++
 rtl/ring_counter_gen.sv | 91 +++++++++
 tb/tb_ring_counter_gen.sv | 132 +++++++++++++
 3 files changed

// File: rtl/ring_counter_gen_if.sv
// Control/status bundle for ring_counter_gen: shift/load controls in, counter state and pulses out.
interface ring_counter_gen_if #(
  parameter int unsigned BITS = 4
);
  logic            en;
  logic            mode;
  logic            dir;
  logic            load;
  logic [BITS-1:0] load_val;
  logic [BITS-1:0] Q;
  logic            wrap;
  logic            err;

  modport master (
    output en, mode, dir, load, load_val,
    input  Q, wrap, err
  );

  modport slave (
    input  en, mode, dir, load, load_val,
    output Q, wrap, err
  );
endinterface

// File: rtl/ring_counter_gen.sv
// Ring / Johnson counter with parallel load, direction control and wrap pulse.
// Optional illegal-state self-correction enabled by defining RING_COUNTER_SELF_CORRECT_EN.
module ring_counter_gen #(
  parameter int unsigned        BITS = 4,
  parameter logic [BITS-1:0]    SEED = {1'b1, {(BITS-1){1'b0}}}
) (
  input logic                clk,
  input logic                ORI,
  ring_counter_gen_if.slave  bus
);

  logic [BITS-1:0] q;
  logic [BITS-1:0] q_next;
  logic [BITS-1:0] shifted;
  logic            fb;
  logic            wrap_q;
  logic            wrap_next;

  // One-step rotation; Johnson mode inverts the bit carried around.
  always_comb begin
    fb      = 1'b0;
    shifted = q;
    if (bus.dir) begin
      fb      = bus.mode ? ~q[BITS-1] : q[BITS-1];
      shifted = {q[BITS-2:0], fb};
    end else begin
      fb      = bus.mode ? ~q[0] : q[0];
      shifted = {fb, q[BITS-1:1]};
    end
  end

`ifdef RING_COUNTER_SELF_CORRECT_EN
  logic [BITS-2:0] edges;
  logic            legal;
  logic            err_q;
  logic            err_next;

  // Ring: one-hot. Johnson: at most one adjacent-bit change, ends not compared.
  always_comb begin
    edges = q[BITS-2:0] ^ q[BITS-1:1];
    if (bus.mode) legal = ($countones(edges) <= 1);
    else          legal = ($countones(q) == 1);
  end
`endif

  always_comb begin
    q_next    = q;
    wrap_next = 1'b0;
`ifdef RING_COUNTER_SELF_CORRECT_EN
    err_next  = 1'b0;
`endif
    if (bus.load) begin
      q_next = bus.load_val;
    end
`ifdef RING_COUNTER_SELF_CORRECT_EN
    else if (bus.en && !legal) begin
      q_next   = SEED;
      err_next = 1'b1;
    end
`endif
    else if (bus.en) begin
      q_next    = shifted;
      wrap_next = (shifted == SEED);
    end
  end

  always_ff @(posedge clk) begin
    if (ORI) begin
      q      <= SEED;
      wrap_q <= 1'b0;
`ifdef RING_COUNTER_SELF_CORRECT_EN
      err_q  <= 1'b0;
`endif
    end else begin
      q      <= q_next;
      wrap_q <= wrap_next;
`ifdef RING_COUNTER_SELF_CORRECT_EN
      err_q  <= err_next;
`endif
    end
  end

  assign bus.Q    = q;
  assign bus.wrap = wrap_q;
`ifdef RING_COUNTER_SELF_CORRECT_EN
  assign bus.err  = err_q;
`else
  assign bus.err  = 1'b0;
`endif

endmodule

// File: tb/tb_ring_counter_gen.sv
// Directed table-driven bench for ring_counter_gen at BITS=4, plus hand-written multi-cycle sequences.
module tb_ring_counter_gen;

  logic clk = 1'b0;
  logic ori;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  ring_counter_gen_if #(.BITS(4)) bus ();

  ring_counter_gen #(.BITS(4)) dut (
    .clk (clk),
    .ORI (ori),
    .bus (bus)
  );

  typedef struct {
    logic       o;
    logic       ld;
    logic       en;
    logic       mode;
    logic       dir;
    logic [3:0] lv;
    logic [3:0] q;
    logic       w;
    logic       er;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic o, input logic ld, input logic en, input logic mode,
                     input logic dir, input logic [3:0] lv, input logic [3:0] q,
                     input logic w, input logic er);
    vec_t v;
    v.o = o; v.ld = ld; v.en = en; v.mode = mode; v.dir = dir;
    v.lv = lv; v.q = q; v.w = w; v.er = er;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic o, input logic ld, input logic en, input logic mode,
                       input logic dir, input logic [3:0] lv);
    ori = o; bus.load = ld; bus.en = en; bus.mode = mode; bus.dir = dir; bus.load_val = lv;
  endtask

  task automatic cmp(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d]: got %b expected %b", name, idx, act, exp);
    end
  endtask

  task automatic step_check(input string tag, input int idx, input logic [3:0] q,
                            input logic w, input logic er);
    @(posedge clk);
    #1;
    cmp({tag, "_q"},    idx, bus.Q, q);
    cmp({tag, "_wrap"}, idx, {3'b000, bus.wrap}, {3'b000, w});
    cmp({tag, "_err"},  idx, {3'b000, bus.err},  {3'b000, er});
  endtask

  logic       sc;
  logic [3:0] ring_seq[4];

  initial begin
`ifdef RING_COUNTER_SELF_CORRECT_EN
    sc = 1'b1;
`else
    sc = 1'b0;
`endif
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);

    //   o  ld  en  mode dir  lv       q        w  er
    add(1, 0, 0, 0, 0, 4'b0000, 4'b1000, 0, 0);   // reset state
    add(0, 0, 1, 0, 0, 4'b0000, 4'b0100, 0, 0);   // ring toward LSB
    add(0, 0, 1, 0, 0, 4'b0000, 4'b0010, 0, 0);
    add(0, 0, 1, 0, 0, 4'b0000, 4'b0001, 0, 0);
    add(0, 0, 1, 0, 0, 4'b0000, 4'b1000, 1, 0);
    add(0, 1, 0, 1, 0, 4'b0000, 4'b0000, 0, 0);   // Johnson from 0000
    add(0, 0, 1, 1, 0, 4'b0000, 4'b1000, 1, 0);
    add(0, 0, 1, 1, 0, 4'b0000, 4'b1100, 0, 0);
    add(0, 0, 1, 1, 0, 4'b0000, 4'b1110, 0, 0);
    add(0, 0, 1, 1, 0, 4'b0000, 4'b1111, 0, 0);
    add(0, 0, 1, 1, 0, 4'b0000, 4'b0111, 0, 0);
    add(0, 0, 1, 1, 0, 4'b0000, 4'b0011, 0, 0);
    add(0, 0, 1, 1, 0, 4'b0000, 4'b0001, 0, 0);
    add(0, 0, 1, 1, 0, 4'b0000, 4'b0000, 0, 0);
    add(0, 0, 1, 1, 0, 4'b0000, 4'b1000, 1, 0);
    add(0, 1, 0, 0, 0, 4'b0100, 4'b0100, 0, 0);   // ring toward MSB, then hold
    add(0, 0, 1, 0, 1, 4'b0000, 4'b1000, 1, 0);
    add(0, 0, 1, 0, 1, 4'b0000, 4'b0001, 0, 0);
    add(0, 0, 0, 0, 1, 4'b0000, 4'b0001, 0, 0);
    add(0, 0, 0, 0, 1, 4'b0000, 4'b0001, 0, 0);
    add(0, 0, 0, 0, 1, 4'b0000, 4'b0001, 0, 0);
    add(1, 1, 1, 0, 0, 4'b0010, 4'b1000, 0, 0);   // ORI beats load
    add(0, 1, 1, 0, 0, 4'b0010, 4'b0010, 0, 0);   // load beats shift
    add(0, 1, 0, 1, 0, 4'b1100, 4'b1100, 0, 0);   // mode switch mid-Johnson
    add(0, 0, 1, 1, 0, 4'b0000, 4'b1110, 0, 0);
    add(0, 0, 1, 0, 0, 4'b0000, sc ? 4'b1000 : 4'b0111, 0, sc);
    add(0, 1, 0, 0, 0, 4'b0110, 4'b0110, 0, 0);   // illegal ring state
    add(0, 0, 1, 0, 0, 4'b0000, sc ? 4'b1000 : 4'b0011, 0, sc);
    add(0, 0, 0, 0, 0, 4'b0000, sc ? 4'b1000 : 4'b0011, 0, 0);
    add(0, 1, 0, 1, 1, 4'b0001, 4'b0001, 0, 0);   // Johnson toward MSB
    add(0, 0, 1, 1, 1, 4'b0000, 4'b0011, 0, 0);
    add(0, 0, 1, 1, 1, 4'b0000, 4'b0111, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].o, vecs[i].ld, vecs[i].en, vecs[i].mode, vecs[i].dir, vecs[i].lv);
      step_check("vec", i, vecs[i].q, vecs[i].w, vecs[i].er);
    end

    // ORI mid-sequence, then first shift must start from the seed
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000);
    step_check("ori_mid", 0, 4'b1000, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000);
    step_check("ori_mid", 1, 4'b0100, 1'b0, 1'b0);

    // Full ring period toward MSB from a non-seed start
    ring_seq[0] = 4'b0100; ring_seq[1] = 4'b1000; ring_seq[2] = 4'b0001; ring_seq[3] = 4'b0010;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0010);
    step_check("ring_per", 0, 4'b0010, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0000);
    for (int k = 0; k < 4; k++)
      step_check("ring_per", k + 1, ring_seq[k], (k == 1), 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
